// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - FSM state encoding (RUN / MISS / BUBBLE)
//   - bubble-class opcode predicate (branch/jump/system/load words that
//     need a dead cycle behind them)
//   - address field width derivations (line offset, index, tag)
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_BUBBLE = 2'd2
  } fetch_state_e;

  // Byte offset bits inside one line: word select plus the 2 byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  // Line index bits (LINES must be a power of two, at least 2).
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits: whatever remains of the address above offset and index.
  function automatic int tag_w(input int addr_w, input int line_words, input int lines);
    return addr_w - off_w(line_words) - idx_w(lines);
  endfunction

  // Opcodes with bit 6 set (branch, jal, jalr, system) or bits 6:4 all
  // zero (loads, fences) must be followed by one empty cycle.
  function automatic logic is_bubble_op(input logic [31:0] word);
    return word[6] | (word[6:4] == 3'b000);
  endfunction

endpackage

// File: rtl/fetch_line_ram.sv
// Direct-mapped line storage for the fetch unit.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits)
//   en            : global enable; all writes and invalidates wait for it
//   inv           : bulk invalidate of every valid bit
//   rd_idx        : combinational read index -> rd_valid, rd_tag, rd_line
//   wr_en, wr_idx : line write strobe and index
//   wr_tag, wr_line, wr_valid : tag, data and valid bit written with the line
// Tag and data arrays carry no reset; only the valid bits matter after reset.
module fetch_line_ram
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          inv,
  input  logic [idx_w(LINES)-1:0]                       rd_idx,
  output logic                                          rd_valid,
  output logic [tag_w(ADDR_W, LINE_WORDS, LINES)-1:0]   rd_tag,
  output logic [32*LINE_WORDS-1:0]                      rd_line,
  input  logic                                          wr_en,
  input  logic [idx_w(LINES)-1:0]                       wr_idx,
  input  logic [tag_w(ADDR_W, LINE_WORDS, LINES)-1:0]   wr_tag,
  input  logic [32*LINE_WORDS-1:0]                      wr_line,
  input  logic                                          wr_valid
);
  localparam int TAG_W     = tag_w(ADDR_W, LINE_WORDS, LINES);
  localparam int LINE_BITS = 32 * LINE_WORDS;

  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Invalidate wins over a same-cycle write so a fill racing a flush
  // never leaves a stale line marked valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = wr_valid;
    if (inv)   valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a direct-mapped instruction cache.
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global enable, all state holds while low
//   stall[4:0]          : pipeline stall vector (only stall[0] is used)
//   use_npc, npc_addr   : redirect request and target address
//   flush               : invalidate the whole cache (fence.i)
//   mem_req, mem_addr   : line fill request, line-aligned zero-extended addr
//   mem_valid, mem_line : fill-complete pulse and line data (word 0 in LSBs)
//   pc, inst, inst_valid: fetched instruction and its address
//   stall_req           : asks the pipeline to wait during a line fill
//   hit_cnt, miss_cnt   : statistics counters
// Optional feature macro: FETCH_UNIT_STATS_EN enables the hit/miss
// counters; without it both counters read as constant zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [4:0]              stall,
  input  logic                    use_npc,
  input  logic [ADDR_W-1:0]       npc_addr,
  input  logic                    flush,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_valid,
  input  logic [32*LINE_WORDS-1:0] mem_line,
  output logic [ADDR_W-1:0]       pc,
  output logic [31:0]             inst,
  output logic                    inst_valid,
  output logic                    stall_req,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);
  localparam int OFF_W     = off_w(LINE_WORDS);
  localparam int IDX_W     = idx_w(LINES);
  localparam int TAG_W     = tag_w(ADDR_W, LINE_WORDS, LINES);
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam logic [ADDR_W-1:0] PC_RESET = ~ADDR_W'(3);

  // Select the 32-bit word addressed by addr out of a full line.
  function automatic logic [31:0] pick_word(input logic [LINE_BITS-1:0] line,
                                            input logic [ADDR_W-1:0]    addr);
    logic [ADDR_W-1:0] sel;
    logic [31:0]       word;
    sel  = (addr >> 2) & ADDR_W'(LINE_WORDS - 1);
    word = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (sel == ADDR_W'(i)) word = line[32*i +: 32];
    end
    return word;
  endfunction

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  mem_req_q, mem_req_d;
  logic                  stall_req_q, stall_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;

  logic [ADDR_W-1:0]     npc;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  hit;
  logic [31:0]           hit_word;
  logic [31:0]           fill_word;
  logic                  wr_en;
  logic                  hit_evt;
  logic                  miss_evt;
  logic                  stall_unused;

  assign stall_unused = ^stall[4:1];

  assign npc       = use_npc ? npc_addr : pc_q + ADDR_W'(4);
  assign hit       = rd_valid && (rd_tag == npc[ADDR_W-1 -: TAG_W]);
  assign hit_word  = pick_word(rd_line, npc);
  assign fill_word = pick_word(mem_line, pc_q);

  fetch_line_ram #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .inv      (flush),
    .rd_idx   (npc[OFF_W +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (pc_q[OFF_W +: IDX_W]),
    .wr_tag   (pc_q[ADDR_W-1 -: TAG_W]),
    .wr_line  (mem_line),
    .wr_valid (~flush)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    mem_req_d    = mem_req_q;
    stall_req_d  = stall_req_q;
    mem_addr_d   = mem_addr_q;
    wr_en        = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!stall[0]) begin
          pc_d = npc;
          if (hit) begin
            hit_evt      = 1'b1;
            inst_d       = hit_word;
            inst_valid_d = 1'b1;
            state_d      = is_bubble_op(hit_word) ? ST_BUBBLE : ST_RUN;
          end else begin
            miss_evt     = 1'b1;
            mem_addr_d   = 32'({npc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
            mem_req_d    = 1'b1;
            stall_req_d  = 1'b1;
            inst_d       = '0;
            inst_valid_d = 1'b0;
            state_d      = ST_MISS;
          end
        end
      end
      // Redirects and stalls are deliberately ignored while the fill is
      // outstanding; pc already holds the address being filled.
      ST_MISS: begin
        if (mem_valid) begin
          wr_en        = 1'b1;
          inst_d       = fill_word;
          inst_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          stall_req_d  = 1'b0;
          state_d      = is_bubble_op(fill_word) ? ST_BUBBLE : ST_RUN;
        end
      end
      ST_BUBBLE: begin
        if (!stall[0]) begin
          inst_d       = '0;
          inst_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= PC_RESET;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      stall_req_q  <= 1'b0;
      mem_addr_q   <= 32'hFFFF_FFFF;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      stall_req_q  <= stall_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign mem_req    = mem_req_q;
  assign stall_req  = stall_req_q;
  assign mem_addr   = mem_addr_q;

`ifdef FETCH_UNIT_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'b0, miss_evt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic evt_unused;
  assign evt_unused = hit_evt ^ miss_evt;
  assign hit_cnt    = '0;
  assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int ADDR_W     = 17;
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 64;
  localparam int LB         = 32 * LINE_WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [4:0]        stall;
  logic              use_npc;
  logic [ADDR_W-1:0] npc_addr;
  logic              flush;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_valid;
  logic [LB-1:0]     mem_line;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              stall_req;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .use_npc(use_npc),
    .npc_addr(npc_addr), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_line(mem_line), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .stall_req(stall_req), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  // Instruction memory image: a fixed program at 0x00, plain addi words
  // up to 0x40 and in 0x400..0x40F, hashed words of mixed classes elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a < 32'h10) begin
      case (a[3:2])
        2'd0:    return 32'h0000_0013;
        2'd1:    return 32'h0010_0093;
        2'd2:    return 32'h0000_A083;
        default: return 32'h0000_0033;
      endcase
    end
    if (a < 32'h40 || (a >= 32'h400 && a < 32'h410)) return 32'h0000_0013;
    h = (a * 32'h9E37_79B1) ^ (a >> 5);
    case (h[18:16])
      3'd0: op = 7'h13;
      3'd1: op = 7'h33;
      3'd2: op = 7'h03;
      3'd3: op = 7'h63;
      3'd4: op = 7'h37;
      3'd5: op = 7'h6F;
      3'd6: op = 7'h13;
      default: op = 7'h73;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [LB-1:0] make_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++)
      l[32*i +: 32] = mem_word({a[31:4], 4'b0} + 32'(4 * i));
    return l;
  endfunction

  function automatic logic is_bub(input logic [31:0] w);
    return w[6] | (w[6:4] == 3'b000);
  endfunction

  function automatic logic [83:0] snap();
    return {pc, inst, inst_valid, mem_req, stall_req, mem_addr};
  endfunction

  function automatic logic [83:0] expv(input logic [16:0] p, input logic [31:0] i,
                                       input logic v, input logic r, input logic s,
                                       input logic [31:0] a);
    return {p, i, v, r, s, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rdy = 1'b1; stall = '0; use_npc = 1'b0; npc_addr = '0;
    flush = 1'b0; mem_valid = 1'b0; mem_line = '0;
  endtask

  task automatic test_reset();
    logic [83:0] e;
    set_idle();
    rst = 1'b1;
    step();
    rdy = 1'b0;
    step();
    e = expv(17'h1FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", snap(), e); end
    total++;
    if ({hit_cnt, miss_cnt} !== 64'h0) begin
      bad++; $display("FAIL reset_counters got=%h/%h want=0/0", hit_cnt, miss_cnt);
    end
    rdy = 1'b1;
  endtask

  task automatic test_cold_start();
    logic [83:0] e;
    logic [31:0] eh, em;
    rst = 1'b0;
    step();
    e = expv(17'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL cold_miss got=%h want=%h", snap(), e); end
    use_npc = 1'b1; npc_addr = 17'h1230; stall = 5'b00001;
    step();
    total++;
    if (snap() !== e) begin bad++; $display("FAIL miss_ignores_redirect got=%h want=%h", snap(), e); end
    set_idle();
    mem_valid = 1'b1; mem_line = make_line(32'h0);
    step();
    mem_valid = 1'b0;
    e = expv(17'h0, 32'h13, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL cold_fill got=%h want=%h", snap(), e); end
    step();
    e = expv(17'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL hit_pc4 got=%h want=%h", snap(), e); end
    step();
    e = expv(17'h8, 32'h0000_A083, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL hit_lw got=%h want=%h", snap(), e); end
    step();
    e = expv(17'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL lw_bubble got=%h want=%h", snap(), e); end
    step();
    e = expv(17'hC, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL after_bubble got=%h want=%h", snap(), e); end
`ifdef FETCH_UNIT_STATS_EN
    eh = 32'd3; em = 32'd1;
`else
    eh = 32'd0; em = 32'd0;
`endif
    total++;
    if ({hit_cnt, miss_cnt} !== {eh, em}) begin
      bad++; $display("FAIL stats_cold got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, eh, em);
    end
  endtask

  task automatic test_stall();
    logic [83:0] e;
    stall = 5'b00001;
    e = expv(17'hC, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (snap() !== e) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", k, snap(), e); end
    end
    stall = 5'b0;
    step();
    e = expv(17'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL stall_resume got=%h want=%h", snap(), e); end
    mem_valid = 1'b1; mem_line = make_line(32'h10);
    step();
    mem_valid = 1'b0;
    step();
    e = expv(17'h14, 32'h13, 1'b1, 1'b0, 1'b0, 32'h10);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL line1_hit got=%h want=%h", snap(), e); end
  endtask

  task automatic test_redirect_evict();
    logic [83:0] e;
    use_npc = 1'b1; npc_addr = 17'h400;
    step();
    use_npc = 1'b0;
    e = expv(17'h400, 32'h0, 1'b0, 1'b1, 1'b1, 32'h400);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL redirect_miss got=%h want=%h", snap(), e); end
    mem_valid = 1'b1; mem_line = make_line(32'h400);
    step();
    mem_valid = 1'b0;
    e = expv(17'h400, 32'h13, 1'b1, 1'b0, 1'b0, 32'h400);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL redirect_fill got=%h want=%h", snap(), e); end
    use_npc = 1'b1; npc_addr = 17'h0;
    step();
    use_npc = 1'b0;
    e = expv(17'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL evicted_line0 got=%h want=%h", snap(), e); end
    mem_valid = 1'b1; mem_line = make_line(32'h0);
    step();
    mem_valid = 1'b0;
    step();
    e = expv(17'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL refill_hit got=%h want=%h", snap(), e); end
  endtask

  task automatic test_flush_fill();
    logic [83:0] e;
    use_npc = 1'b1; npc_addr = 17'h20;
    step();
    use_npc = 1'b0;
    mem_valid = 1'b1; mem_line = make_line(32'h20); flush = 1'b1;
    step();
    mem_valid = 1'b0; flush = 1'b0;
    e = expv(17'h20, 32'h13, 1'b1, 1'b0, 1'b0, 32'h20);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL flush_fill_deliver got=%h want=%h", snap(), e); end
    use_npc = 1'b1; npc_addr = 17'h20;
    step();
    use_npc = 1'b0;
    e = expv(17'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL flush_refetch_miss got=%h want=%h", snap(), e); end
    mem_valid = 1'b1; mem_line = make_line(32'h20);
    step();
    mem_valid = 1'b0;
    use_npc = 1'b1; npc_addr = 17'h0;
    step();
    use_npc = 1'b0;
    e = expv(17'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL flush_all_lines got=%h want=%h", snap(), e); end
    mem_valid = 1'b1; mem_line = make_line(32'h0);
    step();
    mem_valid = 1'b0;
  endtask

  task automatic test_rdy_hold();
    logic [83:0] e;
    rdy = 1'b0;
    step();
    flush = 1'b1;
    step();
    e = expv(17'h0, 32'h13, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL rdy_hold got=%h want=%h", snap(), e); end
    rdy = 1'b1; flush = 1'b0;
    step();
    step();
    e = expv(17'h8, 32'h0000_A083, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL rdy_flush_ignored got=%h want=%h", snap(), e); end
    step();
  endtask

  task automatic test_reset_midfill();
    logic [83:0] e;
    use_npc = 1'b1; npc_addr = 17'h30;
    step();
    use_npc = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 5'b00001;
    mem_valid = 1'b1; mem_line = make_line(32'h30);
    step();
    mem_valid = 1'b0;
    e = expv(17'h1FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL late_fill_ignored got=%h want=%h", snap(), e); end
    stall = 5'b0;
    step();
    e = expv(17'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    total++;
    if (snap() !== e) begin bad++; $display("FAIL post_reset_miss got=%h want=%h", snap(), e); end
  endtask

  // Random traffic against a transaction-level model: the cache is a
  // table of (valid, tag) per index; every delivered word must equal the
  // memory image at the delivered pc.
  task automatic test_random();
    logic [ADDR_W-1:0] m_pc, nx;
    logic [31:0]       m_inst, m_addr, h_exp, mm_exp;
    logic              m_iv, m_req, m_wait, m_bub;
    logic              cv [LINES];
    logic [6:0]        ct [LINES];
    logic [83:0]       e;
    int                lat;
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 17'h1FFFC; m_inst = '0; m_addr = 32'hFFFF_FFFF;
    m_iv = 0; m_req = 0; m_wait = 0; m_bub = 0; h_exp = 0; mm_exp = 0; lat = 0;
    for (int i = 0; i < LINES; i++) begin cv[i] = 1'b0; ct[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      rdy      = ($urandom % 10) != 0;
      stall    = 5'($urandom);
      stall[0] = ($urandom % 5) == 0;
      use_npc  = ($urandom % 6) == 0;
      npc_addr = (($urandom % 8) == 0) ? 17'($urandom) : 17'($urandom_range(0, 32'h7FF));
      npc_addr[1:0] = 2'b00;
      flush    = ($urandom % 40) == 0;
      if (m_wait && lat == 0) begin
        mem_valid = 1'b1; mem_line = make_line({15'b0, m_pc});
      end else if (!m_wait && ($urandom % 12) == 0) begin
        mem_valid = 1'b1; mem_line = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        mem_valid = 1'b0; mem_line = '0;
      end
      if (lat > 0) lat--;
      if (rdy) begin
        if (m_wait) begin
          if (mem_valid) begin
            if (!flush) begin cv[m_pc[9:4]] = 1'b1; ct[m_pc[9:4]] = m_pc[16:10]; end
            m_inst = mem_word({15'b0, m_pc}); m_iv = 1; m_req = 0; m_wait = 0;
            m_bub = is_bub(m_inst);
          end
        end else if (m_bub) begin
          if (!stall[0]) begin m_inst = '0; m_iv = 0; m_bub = 0; end
        end else if (!stall[0]) begin
          nx = use_npc ? npc_addr : m_pc + 17'd4;
          m_pc = nx;
          if (cv[nx[9:4]] && ct[nx[9:4]] == nx[16:10]) begin
            h_exp++; m_inst = mem_word({15'b0, nx}); m_iv = 1; m_bub = is_bub(m_inst);
          end else begin
            mm_exp++; m_addr = {15'b0, nx[16:4], 4'b0}; m_req = 1;
            m_inst = '0; m_iv = 0; m_wait = 1; lat = $urandom_range(0, 3);
          end
        end
        if (flush) for (int i = 0; i < LINES; i++) cv[i] = 1'b0;
      end
      step();
      e = expv(m_pc, m_inst, m_iv, m_req, m_req, m_addr);
      total++;
      if (snap() !== e) begin bad++; $display("FAIL rand_c%0d got=%h want=%h", c, snap(), e); end
`ifdef FETCH_UNIT_STATS_EN
      total++;
      if ({hit_cnt, miss_cnt} !== {h_exp, mm_exp}) begin
        bad++; $display("FAIL rand_stats_c%0d got=%0d/%0d want=%0d/%0d", c, hit_cnt, miss_cnt, h_exp, mm_exp);
      end
`else
      total++;
      if ({hit_cnt, miss_cnt} !== 64'h0) begin
        bad++; $display("FAIL rand_stats_c%0d got=%0d/%0d want=0/0", c, hit_cnt, miss_cnt);
      end
`endif
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_cold_start();
    test_stall();
    test_redirect_evict();
    test_flush_fill();
    test_rdy_hold();
    test_reset_midfill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
